// File: rtl/serial_add16.sv
// Digit-serial adder: D = A + B + Ci computed W bits per clock over N/W steps,
// with a start/ready/done handshake plus carry-out and signed overflow flags.
module serial_add16 #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Co,
  output logic         ovf
);

  localparam int STEPS = N / W;
  localparam int CW    = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg;
  logic [N-1:0]   sa_reg;
  logic [N-1:0]   sb_reg;
  logic [N-1:0]   sr_reg;
  logic           c_reg;
  logic [CW-1:0]  cnt_reg;
  logic           a_msb_reg;
  logic           b_msb_reg;

  logic [W:0]     slice_sum;
  logic [N-1:0]   sr_next;
  logic           last_step;

  // The concatenate-then-shift form keeps the W == N case free of zero-width slices.
  always_comb begin
    slice_sum = {1'b0, sa_reg[W-1:0]} + {1'b0, sb_reg[W-1:0]} + {{W{1'b0}}, c_reg};
    sr_next   = N'({slice_sum[W-1:0], sr_reg} >> W);
    last_step = (cnt_reg == CW'(STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      sr_reg    <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      D         <= '0;
      Co        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_reg    <= A;
            sb_reg    <= B;
            c_reg     <= Ci;
            a_msb_reg <= A[N-1];
            b_msb_reg <= B[N-1];
            cnt_reg   <= '0;
            ready     <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          c_reg   <= slice_sum[W];
          sa_reg  <= sa_reg >> W;
          sb_reg  <= sb_reg >> W;
          sr_reg  <= sr_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) begin
            D         <= sr_next;
            Co        <= slice_sum[W];
            ovf       <= (a_msb_reg == b_msb_reg) && (sr_next[N-1] != a_msb_reg);
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          done      <= 1'b0;
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add16.sv
// Bench for serial_add16: five instances (W = 1, 2, 4, 8, 16) checked against a
// plain-arithmetic reference for result, flags, latency, hold and handshake.
module tb_serial_add16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [5];
  logic [15:0] a_v     [5];
  logic [15:0] b_v     [5];
  logic        ci_v    [5];
  logic        ready_v [5];
  logic        done_v  [5];
  logic [15:0] d_v     [5];
  logic        co_v    [5];
  logic        ovf_v   [5];
  logic [17:0] prev_out [5];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      serial_add16 #(.N(16), .W(1 << gi)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_v[gi]),
        .A     (a_v[gi]),
        .B     (b_v[gi]),
        .Ci    (ci_v[gi]),
        .ready (ready_v[gi]),
        .done  (done_v[gi]),
        .D     (d_v[gi]),
        .Co    (co_v[gi]),
        .ovf   (ovf_v[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {D, Co, ovf} from 17-bit integer addition.
  function automatic logic [17:0] ref_out(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    logic [16:0] s;
    logic        o;
    s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    o = (a[15] == b[15]) && (s[15] != a[15]);
    return {s[15:0], s[16], o};
  endfunction

  function automatic logic [17:0] outs(input int idx);
    return {d_v[idx], co_v[idx], ovf_v[idx]};
  endfunction

  // Called at a falling edge; returns at a falling edge with the instance idle again.
  task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input bit poke, input string tag);
    int          guard;
    int          lat;
    logic [17:0] exp;
    exp   = ref_out(a, b, ci);
    guard = 0;
    while (!ready_v[idx] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ":ready_in"}, 32'(ready_v[idx]), 32'd1);
    a_v[idx]     = a;
    b_v[idx]     = b;
    ci_v[idx]    = ci;
    start_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    a_v[idx]     = 16'($urandom);
    b_v[idx]     = 16'($urandom);
    ci_v[idx]    = 1'($urandom);
    lat = 1;
    while (!done_v[idx] && lat < 40) begin
      chk({tag, ":hold"}, 32'(outs(idx)), 32'(prev_out[idx]));
      chk({tag, ":busy"}, 32'(ready_v[idx]), 32'd0);
      if (poke && lat == 2) begin
        start_v[idx] = 1'b1;
        a_v[idx]     = 16'hAAAA;
        b_v[idx]     = 16'hAAAA;
      end else begin
        start_v[idx] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_v[idx] = 1'b0;
    chk({tag, ":lat"}, 32'(lat), 32'((16 >> idx) + 1));
    chk({tag, ":out"}, 32'(outs(idx)), 32'(exp));
    $display("[TB] W=%0d %s a=%h b=%h ci=%0d -> d=%h co=%0d ovf=%0d lat=%0d",
             1 << idx, tag, a, b, ci, d_v[idx], co_v[idx], ovf_v[idx], lat);
    prev_out[idx] = exp;
    @(negedge clk);
    chk({tag, ":ready_out"}, 32'(ready_v[idx]), 32'd1);
    chk({tag, ":done_low"}, 32'(done_v[idx]), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dlast;
    int ndone;
    for (int i = 0; i < 5; i++) begin
      start_v[i]  = 1'b0;
      a_v[i]      = '0;
      b_v[i]      = '0;
      ci_v[i]     = 1'b0;
      prev_out[i] = '0;
    end
    // Reset with start asserted on the W=4 instance: reset must win.
    rst_n      = 1'b0;
    start_v[2] = 1'b1;
    a_v[2]     = 16'h1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    start_v[2] = 1'b0;
    chk("rst:ready", 32'(ready_v[2]), 32'd1);
    chk("rst:done", 32'(done_v[2]), 32'd0);
    chk("rst:outs", 32'(outs(2)), 32'd0);
    @(negedge clk);
    chk("rst:ready2", 32'(ready_v[2]), 32'd1);

    run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b0, "basic");
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
    run_op(2, 16'h7FFF, 16'h0000, 1'b1, 1'b0, "ovf_ci");
    run_op(2, 16'h8000, 16'h8000, 1'b0, 1'b0, "ovf_neg");
    run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b1, "busy");
    repeat (3) begin
      @(negedge clk);
      chk("idle_hold", 32'(outs(2)), 32'(prev_out[2]));
    end

    // Start held high: one completion every 6 cycles.
    a_v[2]     = 16'h1234;
    b_v[2]     = 16'h4321;
    ci_v[2]    = 1'b0;
    start_v[2] = 1'b1;
    cyc   = 0;
    dlast = -1;
    ndone = 0;
    while (ndone < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done_v[2]) begin
        if (dlast >= 0) chk("thru:gap", 32'(cyc - dlast), 32'd6);
        chk("thru:out", 32'(outs(2)), 32'(ref_out(16'h1234, 16'h4321, 1'b0)));
        dlast = cyc;
        ndone++;
      end
    end
    start_v[2] = 1'b0;
    chk("thru:count", 32'(ndone), 32'd3);
    prev_out[2] = ref_out(16'h1234, 16'h4321, 1'b0);
    $display("[TB] W=4 thru completions=%0d", ndone);
    @(negedge clk);

    // Reset landing on RUN step 2 with a carry in flight.
    a_v[2]     = 16'hFFFF;
    b_v[2]     = 16'h0001;
    ci_v[2]    = 1'b1;
    start_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst:ready", 32'(ready_v[2]), 32'd1);
    chk("midrst:done", 32'(done_v[2]), 32'd0);
    chk("midrst:outs", 32'(outs(2)), 32'd0);
    $display("[TB] W=4 mid-run reset ready=%0d d=%h", ready_v[2], d_v[2]);
    for (int i = 0; i < 5; i++) prev_out[i] = '0;
    run_op(2, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 5; i++) begin
      if (i != 2) begin
        for (int v = 0; v < 1000; v++)
          run_op(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd");
      end else begin
        for (int v = 0; v < 50; v++)
          run_op(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
